// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter: NSRC drivers, NDST loaders, registered bus,
// saturating conflict counter and sticky no-driver load error.
module bus_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NSRC  = 3,
  parameter int unsigned NDST  = 3,
  parameter int unsigned CNTW  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NSRC-1:0]        src_req,
  input  logic [NSRC*WIDTH-1:0]  src_data,
  input  logic [NDST-1:0]        dst_load,
  output logic [WIDTH-1:0]       bus_data,
  output logic [NSRC-1:0]        src_grant,
  output logic [NDST-1:0]        dst_valid,
  output logic [CNTW-1:0]        conflict_cnt,
  output logic                   load_err
);

  localparam int unsigned PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    hi_win, lo_win, win, next_ptr;
  logic             hi_found, lo_found;
  logic [WIDTH-1:0] sel_data;
  logic             multi_req;

  // Winner is the lowest requester at or above ptr; failing that, the lowest
  // requester overall (the wrapped part of the search).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (src_req[k] && !lo_found) begin
        lo_found = 1'b1;
        lo_win   = k[PW-1:0];
      end
      if (src_req[k] && !hi_found && (k >= 32'(ptr))) begin
        hi_found = 1'b1;
        hi_win   = k[PW-1:0];
      end
    end
    win = hi_found ? hi_win : lo_win;
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (k == 32'(win)) sel_data = src_data[k*WIDTH +: WIDTH];
    end
  end

  assign next_ptr  = (win == PW'(NSRC - 1)) ? '0 : win + 1'b1;
  assign multi_req = ($countones(src_req) >= 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_data     <= '0;
      src_grant    <= '0;
      dst_valid    <= '0;
      ptr          <= '0;
      conflict_cnt <= '0;
      load_err     <= 1'b0;
    end else begin
      if (lo_found) begin
        bus_data  <= sel_data;
        src_grant <= NSRC'(1) << win;
        dst_valid <= dst_load;
        ptr       <= next_ptr;
      end else begin
        src_grant <= '0;
        dst_valid <= '0;
        if (|dst_load) load_err <= 1'b1;
      end
      if (multi_req && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, bus data width in bits.
REQ-002 Parameter NSRC, default 3, number of bus drivers (sources); legal range 2..8.
REQ-003 Parameter NDST, default 3, number of bus loaders (destinations); legal range 1..8.
REQ-004 Parameter CNTW, default 8, width of the conflict counter.
REQ-005 Port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-006 Port rst_n, input, 1, reset; asynchronous and active-low.
REQ-007 Port src_req, input, NSRC, per-source request to drive the bus; this is the successor of the per-unit enable.
REQ-008 Port src_data, input, NSRC*WIDTH, source data; source k occupies bits [k*WIDTH +: WIDTH].
REQ-009 Port dst_load, input, NDST, per-destination load request, sampled in the same cycle as src_req.
REQ-010 Port bus_data, output, WIDTH, registered bus value.
REQ-011 Port src_grant, output, NSRC, registered one-hot grant identifying the source whose data bus_data holds this cycle.
REQ-012 Port dst_valid, output, NDST, registered strobes; dst_valid[j]=1 means destination j shall capture bus_data this cycle.
REQ-013 Port conflict_cnt, output, CNTW, saturating count of cycles with two or more simultaneous requests.
REQ-014 Port load_err, output, 1, sticky flag for a load requested with no driver.

Function
REQ-015 Arbitration: round-robin over src_req, starting the search at pointer ptr (0..NSRC-1) and moving upward with wrap to 0; the first requesting index k wins.
REQ-016 Grant takes effect at the rising edge: bus_data <= src_data[k], src_grant <= one-hot(k), ptr <= (k+1) mod NSRC; latency from request to bus_data is exactly 1 cycle.
REQ-017 No request: bus_data holds its previous value (bus keeper); src_grant <= 0; ptr unchanged.
REQ-018 Losing requesters are not queued; a source that keeps src_req high is granted in a later cycle when ptr reaches it; no source waits more than NSRC-1 cycles while it requests continuously.
REQ-019 Load: at the edge, dst_valid <= dst_load when any src_req=1, else dst_valid <= 0; multiple destinations may load the same value in the same cycle.
REQ-020 dst_load nonzero with src_req = 0: dst_valid stays 0; load_err <= 1; load_err stays 1 until reset.
REQ-021 Conflict: each cycle with popcount(src_req) >= 2 increments conflict_cnt by 1; the count saturates at 2^CNTW-1 and does not wrap.
REQ-022 All outputs come directly from flops; there is no combinational path from any input to any output.
REQ-023 Unequal parameter combinations (NSRC not a power of two) shall wrap ptr correctly, with no out-of-range index.

Reset
REQ-024 When rst_n = 0, the block shall immediately and asynchronously set bus_data = 0, src_grant = 0, dst_valid = 0, ptr = 0, conflict_cnt = 0 and load_err = 0, regardless of clk.
REQ-025 Reset asserted mid-transfer: no grant or strobe issued before reset survives; the first edge after rst_n rises arbitrates afresh from ptr = 0.

Verification (WIDTH=8, NSRC=3, NDST=3, CNTW=8)
REQ-026 Single transfer: src_req=001, src_data0=AA, dst_load=010 -> next cycle: bus_data=AA, src_grant=001, dst_valid=010, conflict_cnt=0.
REQ-027 Contention with round-robin: ptr=0, src_req=011 held for 2 cycles with data0=AA and data1=55 -> bus_data=AA with grant=001, then bus_data=55 with grant=010; conflict_cnt=2.
REQ-028 Wrap-around: only src2 requests (data2=3C) -> grant=100, ptr=0; then src_req=101 -> grant=001.
REQ-029 Load with no driver: src_req=000, dst_load=001 after bus_data=55 -> dst_valid=000, bus_data=55 (held), load_err=1, and load_err stays 1 through later valid transfers.
REQ-030 Saturation: src_req=111 for 300 cycles -> conflict_cnt=FF and it stays FF; grants rotate 001,010,100 in sequence.
REQ-031 Asynchronous reset: rst_n driven low between clock edges during a transfer -> all outputs become 0 before the next edge; after release, src_req=010 -> grant=010, ptr=2.
